// File: rtl/tdm_demux1to8_pkg.sv
// Shared definitions for the 8-slot TDM receive path.
//   N_SLOTS : slots per frame (fixed at 8)
//   SEL_W   : slot index width
//   W       : bits per slot sample
//   state_e : receiver state (HUNT searching for sync, RUN aligned)
//   frame_t : one frame of slot samples, slot k at index k
package tdm_demux1to8_pkg;
  localparam int N_SLOTS = 8;
  localparam int SEL_W   = 3;
  localparam int W       = 1;

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_e;

  typedef logic [N_SLOTS-1:0][W-1:0] frame_t;
endpackage

// File: rtl/tdm_demux1to8_if.sv
// Link-side and consumer-side signal bundle of the TDM demux.
//   en          : 1 = freeze the block (no capture)
//   sync        : frame marker, high with the slot-0 sample
//   d           : serial sample for the current slot
//   o           : last complete frame, slot k at o[k*W +: W]
//   frame_valid : 1-cycle pulse, o just updated
//   sync_err    : 1-cycle pulse, sync seen mid-frame
//   locked      : 1 while aligned (RUN)
//   slot        : slot index expected on next capture
// master = stimulus/consumer side, slave = the demux.
interface tdm_demux1to8_if;
  import tdm_demux1to8_pkg::*;

  logic                 en;
  logic                 sync;
  logic [W-1:0]         d;
  logic [N_SLOTS*W-1:0] o;
  logic                 frame_valid;
  logic                 sync_err;
  logic                 locked;
  logic [SEL_W-1:0]     slot;

  modport master (
    output en, sync, d,
    input  o, frame_valid, sync_err, locked, slot
  );

  modport slave (
    input  en, sync, d,
    output o, frame_valid, sync_err, locked, slot
  );
endinterface

// File: rtl/tdm_demux1to8_slot_cnt.sv
// Slot index counter for the TDM demux.
//   clk, rst_n : clock, synchronous active-low reset (slot -> 0)
//   clr_to_1   : load 1 (slot 0 was just captured from a sync)
//   inc        : advance, wrapping 7 -> 0
//   hold       : freeze, overrides clr_to_1 and inc
//   slot       : current slot index
//   wrap       : slot is the last slot of the frame
module tdm_slot_cnt
  import tdm_demux1to8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_to_1,
  input  logic             inc,
  input  logic             hold,
  output logic [SEL_W-1:0] slot,
  output logic             wrap
);
  logic [SEL_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (!hold) begin
      if (clr_to_1)  slot_d = SEL_W'(1);
      else if (inc)  slot_d = slot_q + 1'b1;  // natural overflow gives the 7 -> 0 wrap
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot = slot_q;
  assign wrap = (slot_q == SEL_W'(N_SLOTS - 1));
endmodule

// File: rtl/tdm_demux1to8.sv
// Receive end of the 8-slot TDM link: one serial sample per clock is
// collected into a shadow frame; the edge that captures slot 7 publishes
// the whole frame on the registered parallel bus with a frame_valid pulse.
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset, discards any partial frame
//   bus   : tdm_demux1to8_if.slave (en, sync, d in; o, frame_valid,
//           sync_err, locked, slot out), all outputs registered
module tdm_demux1to8
  import tdm_demux1to8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  tdm_demux1to8_if.slave   bus
);
  state_e               state_q, state_d;
  frame_t               shadow_q, shadow_d;
  logic [N_SLOTS*W-1:0] o_q, o_d;
  logic                 fv_q, fv_d;
  logic                 se_q, se_d;
  logic                 clr, inc;
  logic [SEL_W-1:0]     slot;
  logic                 wrap;

  tdm_slot_cnt u_slot_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_to_1 (clr),
    .inc      (inc),
    .hold     (bus.en),
    .slot     (slot),
    .wrap     (wrap)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    o_d      = o_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    clr      = 1'b0;
    inc      = 1'b0;
    if (!bus.en) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync) begin
            shadow_d[0] = bus.d;
            clr         = 1'b1;
            state_d     = RUN;
          end
        end
        RUN: begin
          if (bus.sync) begin
            // A sync away from slot 0 restarts the frame; the stale partial
            // frame is wiped so it can never leak into a published frame.
            clr = 1'b1;
            if (slot != '0) begin
              se_d     = 1'b1;
              shadow_d = '0;
            end
            shadow_d[0] = bus.d;
          end else begin
            shadow_d[slot] = bus.d;
            inc            = 1'b1;
            if (wrap) begin
              // Slot 7 goes straight to o; its shadow copy is not yet visible.
              o_d  = {bus.d, shadow_q[N_SLOTS-2:0]};
              fv_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      o_q      <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      o_q      <= o_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
    end
  end

  assign bus.o           = o_q;
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = se_q;
  assign bus.locked      = (state_q == RUN);
  assign bus.slot        = slot;
endmodule

// File: tb/tb_tdm_demux1to8.sv
module tb_tdm_demux1to8;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  tdm_demux1to8_if bus();

  tdm_demux1to8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected pulse: which pulse, the frame on o, and the edge number it follows.
  typedef struct {
    bit         fv;
    bit         se;
    logic [7:0] o;
    int         cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, optionally registering the pulse the edge
  // capturing them must produce; returns #1 after that edge.
  task automatic drv(input logic e, input logic s, input logic dd,
                     input bit efv = 1'b0, input bit ese = 1'b0,
                     input logic [7:0] eo = 8'h00);
    bus.en   = e;
    bus.sync = s;
    bus.d    = dd;
    if (efv || ese) q.push_back(exp_t'{efv, ese, eo, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  // Send one frame slot 0 first, checking the slot index after each capture.
  task automatic send_frame(input logic [7:0] v, input bit with_sync);
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, with_sync && (i == 0), v[i], (i == 7), 1'b0, v);
      chk("slot_adv", 32'(bus.slot), 32'((i + 1) % 8));
    end
  endtask

  // Monitor: every pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (bus.frame_valid === 1'b1 || bus.sync_err === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, bus.frame_valid, bus.sync_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("pulse_fv",  32'(bus.frame_valid), 32'(e.fv));
        chk("pulse_se",  32'(bus.sync_err),    32'(e.se));
        chk("pulse_o",   32'(bus.o),           32'(e.o));
        chk("pulse_cyc", 32'(cyc),             32'(e.cyc));
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b0;
    bus.sync = 1'b0;
    bus.d    = 1'b0;

    // Reset state
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b1);
    chk("rst_o",      32'(bus.o),           32'd0);
    chk("rst_fv",     32'(bus.frame_valid), 32'd0);
    chk("rst_se",     32'(bus.sync_err),    32'd0);
    chk("rst_locked", 32'(bus.locked),      32'd0);
    chk("rst_slot",   32'(bus.slot),        32'd0);
    rst_n = 1'b1;

    // HUNT: no sync, d toggling, nothing moves
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, 1'b0, 1'(i % 2));
      chk("hunt_locked", 32'(bus.locked), 32'd0);
      chk("hunt_slot",   32'(bus.slot),   32'd0);
    end

    // Aligned frame: d = 1,0,1,1,0,1,0,0 from slot 0 -> 8'b0010_1101
    send_frame(8'h2D, 1'b1);
    chk("aligned_locked", 32'(bus.locked), 32'd1);
    chk("aligned_o",      32'(bus.o),      32'h2D);

    // en stall of 3 cycles after slot 4; sync/d during stall are ignored
    drv(1'b0, 1'b1, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b1);
      chk("stall_slot", 32'(bus.slot), 32'd5);
      chk("stall_o",    32'(bus.o),    32'h2D);
    end
    drv(1'b0, 1'b0, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h2D);
    chk("stall_slot_wrap", 32'(bus.slot), 32'd0);

    // Misaligned sync at slot 5, then seven 1s -> 8'hFF
    drv(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 1'b0);
    chk("mis_pre_slot", 32'(bus.slot), 32'd5);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h2D);
    chk("mis_slot",   32'(bus.slot),   32'd1);
    chk("mis_o_kept", 32'(bus.o),      32'h2D);
    chk("mis_locked", 32'(bus.locked), 32'd1);
    for (int i = 0; i < 7; i++) drv(1'b0, 1'b0, 1'b1, (i == 6), 1'b0, 8'hFF);
    chk("mis_o_ff", 32'(bus.o), 32'hFF);

    // Back-to-back: sync only on the first frame
    send_frame(8'h3C, 1'b1);
    send_frame(8'hA5, 1'b0);
    chk("b2b_o", 32'(bus.o), 32'hA5);

    // Reset mid-frame after 3 RUN captures, then a clean restart
    drv(1'b0, 1'b1, 1'b1);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1);
    chk("mid_slot", 32'(bus.slot), 32'd3);
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 1'b1);
    chk("mrst_o",      32'(bus.o),           32'd0);
    chk("mrst_fv",     32'(bus.frame_valid), 32'd0);
    chk("mrst_se",     32'(bus.sync_err),    32'd0);
    chk("mrst_locked", 32'(bus.locked),      32'd0);
    chk("mrst_slot",   32'(bus.slot),        32'd0);
    rst_n = 1'b1;
    send_frame(8'h96, 1'b1);
    chk("restart_o", 32'(bus.o), 32'h96);

    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
